tablero_naval: RTL and testbench

Battleship game board store for the Lab 3 sequential-logic controller. Holds two 5×5 boards, one for the player and one for the PC, each cell a 2-bit state code. On a fill command it initialises both boards to water; game logic upstream reads the boards combinationally.

---
 rtl/tablero_pkg.sv | 11 +
 rtl/tablero_banco.sv | 14 +
 rtl/tablero_naval.sv | 19 +
 tb/tb_tablero_naval.sv | 107 ++++++++++
 4 files changed

// File: rtl/tablero_pkg.sv
// tablero_pkg: shared board dimension, cell codes and types for the battleship board store
package tablero_pkg;
  localparam int N = 5;
  typedef logic [1:0] celda_t;
  localparam celda_t CELDA_VACIA   = 2'b00;
  localparam celda_t CELDA_AGUA    = 2'b01;
  localparam celda_t CELDA_BARCO   = 2'b10;
  localparam celda_t CELDA_IMPACTO = 2'b11;
  typedef celda_t tablero_t [N][N];
  typedef enum logic {VACIO, AGUA} estado_t;
endpackage

// File: rtl/tablero_banco.sv
// tablero_banco: NxN cell register bank with sync active-low clear and fill-with-water
module tablero_banco
  import tablero_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fill,
  output logic [1:0] celdas [N][N]
);
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        celdas[i][j] <= !rst ? CELDA_VACIA : fill ? CELDA_AGUA : celdas[i][j];
endmodule

// File: rtl/tablero_naval.sv
// tablero_naval: player and PC boards, cleared on reset and filled with water on decision
module tablero_naval
  import tablero_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       decision,
  output logic [1:0] tablero_jugador [N][N],
  output logic [1:0] tablero_pc      [N][N]
);
  estado_t estado;
  logic fill;
  // Banks only load on the VACIO->AGUA step; refills in AGUA are no-ops anyway.
  assign fill = decision && estado == VACIO;
  always_ff @(posedge clk)
    estado <= !rst ? VACIO : decision ? AGUA : estado;
  tablero_banco u_jugador (.clk(clk), .rst(rst), .fill(fill), .celdas(tablero_jugador));
  tablero_banco u_pc      (.clk(clk), .rst(rst), .fill(fill), .celdas(tablero_pc));
endmodule

// File: tb/tb_tablero_naval.sv
// tb_tablero_naval: table-driven, hand-written and randomized checks of tablero_naval
module tb_tablero_naval;
  logic clk = 0;
  logic rst = 0;
  logic decision = 0;
  logic [1:0] tj [5][5];
  logic [1:0] tp [5][5];
  int errors = 0;
  int checks = 0;
  bit lleno = 0;

  tablero_naval dut (.clk(clk), .rst(rst), .decision(decision),
                     .tablero_jugador(tj), .tablero_pc(tp));

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       d;
    logic [1:0] e;
    string      nm;
  } vec_t;

  vec_t vecs [11];

  task automatic step(input logic r, input logic d);
    rst = r;
    decision = d;
    @(posedge clk);
    #1;
    if (!r) lleno = 0;
    else if (d) lleno = 1;
  endtask

  task automatic check(input string nm, input logic [1:0] e);
    int bj = 0;
    int bp = 0;
    logic [1:0] aj = e;
    logic [1:0] ap = e;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (tj[i][j] !== e) begin bj++; aj = tj[i][j]; end
        if (tp[i][j] !== e) begin bp++; ap = tp[i][j]; end
      end
    checks += 2;
    if (bj != 0) begin
      errors++;
      $display("FAIL %s jugador: %0d cells wrong, got %b want %b", nm, bj, aj, e);
    end
    if (bp != 0) begin
      errors++;
      $display("FAIL %s pc: %0d cells wrong, got %b want %b", nm, bp, ap, e);
    end
  endtask

  task automatic check_cell(input int i, input int j, input logic [1:0] e);
    checks += 2;
    if (tj[i][j] !== e) begin
      errors++;
      $display("FAIL cell jugador[%0d][%0d]: got %b want %b", i, j, tj[i][j], e);
    end
    if (tp[i][j] !== e) begin
      errors++;
      $display("FAIL cell pc[%0d][%0d]: got %b want %b", i, j, tp[i][j], e);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 2'b00, "reset"};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, "idle1"};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, "idle2"};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, "fill"};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, "hold1"};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, "hold2"};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, "hold3"};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, "refill1"};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, "refill2"};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, "rst_prio"};
    vecs[10] = '{1'b1, 1'b1, 2'b01, "fill_again"};
    for (int k = 0; k < 11; k++) begin
      step(vecs[k].r, vecs[k].d);
      check(vecs[k].nm, vecs[k].e);
    end
    check_cell(0, 0, 2'b01);
    check_cell(0, 4, 2'b01);
    check_cell(4, 0, 2'b01);
    check_cell(4, 4, 2'b01);
    check_cell(2, 2, 2'b01);
    // After reset from AGUA, releasing reset alone must not refill.
    step(1'b0, 1'b0);
    check("rst_from_agua", 2'b00);
    step(1'b1, 1'b0);
    check("release_idle1", 2'b00);
    step(1'b1, 1'b0);
    check("release_idle2", 2'b00);
    step(1'b1, 1'b1);
    check("pulse_fill", 2'b01);
    step(1'b1, 1'b0);
    check("pulse_hold", 2'b01);
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0);
      check("random", lleno ? 2'b01 : 2'b00);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
